// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache with single outstanding line fill
// Hits answer one cycle after the request; misses go IDLE -> REQ -> WAIT and forward the fill word.
module icache #(
    parameter int BLOCK_WIDTH = 1,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                                  Sys_clk,
    input  logic                                  Sys_rst,
    input  logic                                  Sys_rdy,
    input  logic                                  IFIC_en,
    input  logic [31:0]                           IFIC_addr,
    input  logic                                  IFIC_flush,
    output logic                                  ICIF_en,
    output logic [31:0]                           ICIF_data,
    output logic                                  ICMC_en,
    output logic [31:0]                           ICMC_addr,
    input  logic                                  MCIC_en,
    input  logic [32*(1<<BLOCK_WIDTH)-1:0]        MCIC_block
);
    localparam int WORDS  = 1 << BLOCK_WIDTH;
    localparam int LINES  = 1 << INDEX_WIDTH;
    localparam int OFF_LO = 2;
    localparam int IDX_LO = OFF_LO + BLOCK_WIDTH;
    localparam int TAG_LO = IDX_LO + INDEX_WIDTH;
    localparam int TAG_W  = 32 - TAG_LO;

    typedef logic [WORDS-1:0][31:0] line_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                 state;
    line_t                  data_mem [LINES];
    logic [TAG_W-1:0]       tag_mem  [LINES];
    logic [LINES-1:0]       valid;
    logic [BLOCK_WIDTH-1:0] req_off;

    logic [BLOCK_WIDTH-1:0] fetch_off;
    logic [INDEX_WIDTH-1:0] fetch_idx;
    logic [TAG_W-1:0]       fetch_tag;
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_W-1:0]       fill_tag;
    line_t                  hit_line;
    line_t                  fill_line;
    logic                   hit;
    logic                   fill_we;
    logic                   unused_bits;

    assign fetch_off = IFIC_addr[IDX_LO-1:OFF_LO];
    assign fetch_idx = IFIC_addr[TAG_LO-1:IDX_LO];
    assign fetch_tag = IFIC_addr[31:TAG_LO];
    // The held fill address doubles as the latched index/tag of the pending miss.
    assign fill_idx  = ICMC_addr[TAG_LO-1:IDX_LO];
    assign fill_tag  = ICMC_addr[31:TAG_LO];
    assign hit_line  = data_mem[fetch_idx];
    assign fill_line = MCIC_block;
    assign hit       = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
    assign fill_we   = Sys_rst && Sys_rdy && !IFIC_flush && (state == WAIT) && MCIC_en;
    assign unused_bits = &{1'b0, IFIC_addr[OFF_LO-1:0], ICMC_addr[IDX_LO-1:0]};

    always_ff @(posedge Sys_clk) begin
        if (fill_we) begin
            data_mem[fill_idx] <= fill_line;
            tag_mem[fill_idx]  <= fill_tag;
        end
    end

    always_ff @(posedge Sys_clk) begin
        if (!Sys_rst) begin
            state     <= IDLE;
            valid     <= '0;
            req_off   <= '0;
            ICIF_en   <= 1'b0;
            ICIF_data <= '0;
            ICMC_en   <= 1'b0;
            ICMC_addr <= '0;
        end else if (Sys_rdy) begin
            ICIF_en <= 1'b0;
            if (IFIC_flush) begin
                state   <= IDLE;
                ICMC_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (IFIC_en && !ICIF_en) begin
                            if (hit) begin
                                ICIF_en   <= 1'b1;
                                ICIF_data <= hit_line[fetch_off];
                            end else begin
                                ICMC_en   <= 1'b1;
                                ICMC_addr <= {IFIC_addr[31:IDX_LO], {IDX_LO{1'b0}}};
                                req_off   <= fetch_off;
                                state     <= REQ;
                            end
                        end
                    end
                    // MCIC_en may still be high from the previous fill here.
                    REQ: state <= WAIT;
                    WAIT: begin
                        if (MCIC_en) begin
                            valid[fill_idx] <= 1'b1;
                            ICMC_en         <= 1'b0;
                            ICIF_en         <= 1'b1;
                            ICIF_data       <= fill_line[req_off];
                            state           <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
